// File: rtl/count_event_tracker_pkg.sv
// rtl/count_event_tracker_pkg.sv - shared types and defaults for the count event tracker
package count_event_tracker_pkg;

  localparam int DEF_CNT_W       = 4;
  localparam int DEF_WRAP_W      = 8;
  localparam int DEF_HOLD_CYCLES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/count_event_tracker_sat_counter.sv
// rtl/count_event_tracker_sat_counter.sv - saturating up counter with sync clear
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/count_event_tracker.sv
// rtl/count_event_tracker.sv - step/wrap checker and arm-match-hold trigger for a counter stream
module count_event_tracker
  import count_event_tracker_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int WRAP_W      = DEF_WRAP_W,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CNT_W-1:0]  cnt_in,
  input  logic              cnt_vld,
  input  logic              arm,
  input  logic [CNT_W-1:0]  target,
  input  logic              clr,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wraps,
  output logic              step_err,
  output logic              match_pulse,
  output logic              trig,
  output logic              busy
);

  localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] prev_cnt, prev_n, prev_inc;
  logic             seen, seen_n;
  logic             wrap_hit, err_hit;

  logic [CNT_W-1:0] tgt_q, tgt_n;
  logic [HC_W-1:0]  hold_cnt, hold_n;
  state_t           state, state_n;
  logic             match_n;

  assign prev_inc = prev_cnt + 1'b1;

  // Step checker: the first valid sample after reset/clr only seeds prev_cnt.
  always_comb begin
    prev_n   = prev_cnt;
    seen_n   = seen;
    wrap_hit = 1'b0;
    err_hit  = 1'b0;
    if (clr) begin
      seen_n = 1'b0;
    end else if (cnt_vld) begin
      prev_n = cnt_in;
      seen_n = 1'b1;
      if (seen && (cnt_in != prev_cnt)) begin
        if (cnt_in == prev_inc) begin
          wrap_hit = (prev_cnt == {CNT_W{1'b1}});
        end else begin
          err_hit = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_cnt   <= '0;
      seen       <= 1'b0;
      step_err   <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      prev_cnt   <= prev_n;
      seen       <= seen_n;
      step_err   <= clr ? 1'b0 : (step_err | err_hit);
      wrap_pulse <= wrap_hit;
    end
  end

  sat_counter #(
    .WIDTH (WRAP_W)
  ) u_wraps (
    .clk   (clk),
    .reset (reset),
    .inc   (wrap_hit),
    .clr   (clr),
    .count (wraps)
  );

  // Matcher FSM; arm is only honoured from IDLE so tgt_q is stable while armed or holding.
  always_comb begin
    state_n = state;
    hold_n  = hold_cnt;
    tgt_n   = tgt_q;
    match_n = 1'b0;
    if (clr) begin
      state_n = IDLE;
      hold_n  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (arm) begin
            state_n = ARMED;
            tgt_n   = target;
          end
        end
        ARMED: begin
          if (cnt_vld && (cnt_in == tgt_q)) begin
            state_n = HOLD;
            match_n = 1'b1;
            hold_n  = HOLD_LAST;
          end
        end
        HOLD: begin
          if (hold_cnt == '0) begin
            state_n = IDLE;
          end else begin
            hold_n = hold_cnt - 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          hold_n  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      tgt_q       <= '0;
      match_pulse <= 1'b0;
      trig        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      hold_cnt    <= hold_n;
      tgt_q       <= tgt_n;
      match_pulse <= match_n;
      trig        <= (state_n == HOLD);
      busy        <= (state_n != IDLE);
    end
  end

endmodule
